sram_arbiter: RTL

Sequencer and arbiter for the shared external 128K×8 asynchronous SRAM. It serialises CPU, VPU video-fetch and (optionally) SD/DMA accesses onto one SRAM port and generates registered, glitch-free CS2/OE_n/WE_n strobes with a programmable wait-state count. It stalls the CPU via `hold` until the CPU's external access completes. It sits between the top-level address decode and the SRAM pins, and replaces the combinational strobe muxing.

---
 rtl/sram_arb_pkg.sv | 24 ++
 rtl/sram_arb_prio.sv | 22 ++
 rtl/sram_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared FSM state and requester encodings for the SRAM arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RQ_CPU = 2'd0,
    RQ_VPU = 2'd1,
    RQ_DMA = 2'd2
  } rq_id_t;

  localparam int WS_CNT_W = 3;

  // Wait-state count (0..7) squeezed into the strobe counter width
  function automatic logic [WS_CNT_W-1:0] ws_last(input int ws);
    return WS_CNT_W'(ws);
  endfunction

endpackage

// File: rtl/sram_arb_prio.sv
// rtl/sram_arb_prio.sv - combinational grant pick: VPU > DMA > CPU, CPU forced once the VPU burst limit is hit
module sram_arb_prio
  import sram_arb_pkg::*;
(
  input  logic   i_cpu_req,
  input  logic   i_vpu_req,
  input  logic   i_dma_req,
  input  logic   i_run_full,
  output logic   o_grant,
  output rq_id_t o_grant_id
);

  // Fixed priority with a fairness override that lets a waiting CPU past a long VPU burst
  always_comb begin
    o_grant    = i_cpu_req | i_vpu_req | i_dma_req;
    o_grant_id = RQ_CPU;
    if (i_cpu_req && i_run_full) o_grant_id = RQ_CPU;
    else if (i_vpu_req)          o_grant_id = RQ_VPU;
    else if (i_dma_req)          o_grant_id = RQ_DMA;
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - CPU/VPU access sequencer for the shared async SRAM; DMA port added by SRAM_ARB_DMA_EN
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_STATES   = 1,
  parameter int VPU_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_hold,
  input  logic        vpu_req,
  input  logic [15:0] vpu_addr,
  output logic [7:0]  vpu_rdata,
  output logic        vpu_ack,
`ifdef SRAM_ARB_DMA_EN
  input  logic        dma_req,
  input  logic        dma_rw,
  input  logic [16:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
`endif
  output logic [16:0] sram_ad,
  input  logic [7:0]  sram_dq_i,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_cs2,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam int RUN_W = (VPU_BURST_MAX < 1) ? 1 : $clog2(VPU_BURST_MAX + 1);
  localparam logic [RUN_W-1:0]    RUN_MAX = RUN_W'(VPU_BURST_MAX);
  localparam logic [WS_CNT_W-1:0] WS_LAST = ws_last(WAIT_STATES);

  state_t               r_state, w_state_nxt;
  rq_id_t               r_id, w_grant_id;
  logic                 r_rw;
  logic [16:0]          r_ad;
  logic [7:0]           r_dq_o;
  logic                 r_dq_oe, r_cs2, r_oe_n, r_we_n;
  logic [WS_CNT_W-1:0]  r_ws_cnt;
  logic [RUN_W-1:0]     r_vpu_run;
  logic [7:0]           r_cpu_rdata, r_vpu_rdata;
  logic                 r_cpu_ack, r_vpu_ack;
  logic                 w_grant, w_load, w_run_full, w_strobe_last, w_dma_req, w_rw_nxt;
  logic                 w_sel_rw;
  logic [16:0]          w_sel_addr;
  logic [7:0]           w_sel_wdata;
`ifdef SRAM_ARB_DMA_EN
  logic [7:0]           r_dma_rdata;
  logic                 r_dma_ack;
  assign w_dma_req = dma_req;
  assign dma_rdata = r_dma_rdata;
  assign dma_ack   = r_dma_ack;
`else
  assign w_dma_req = 1'b0;
`endif

  assign w_run_full    = (r_vpu_run == RUN_MAX);
  assign w_strobe_last = (r_ws_cnt == WS_LAST);
  assign w_rw_nxt      = w_load ? w_sel_rw : r_rw;

  sram_arb_prio u_prio (
    .i_cpu_req  (cpu_req),
    .i_vpu_req  (vpu_req),
    .i_dma_req  (w_dma_req),
    .i_run_full (w_run_full),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  // Route the winning requester's command to the latch inputs
  always_comb begin
    w_sel_rw    = cpu_rw;
    w_sel_addr  = cpu_addr;
    w_sel_wdata = cpu_wdata;
    case (w_grant_id)
      RQ_VPU: begin
        w_sel_rw    = 1'b1;
        w_sel_addr  = {1'b0, vpu_addr};
        w_sel_wdata = 8'h00;
      end
`ifdef SRAM_ARB_DMA_EN
      RQ_DMA: begin
        w_sel_rw    = dma_rw;
        w_sel_addr  = dma_addr;
        w_sel_wdata = dma_wdata;
      end
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; w_load marks the IDLE cycle that accepts a grant
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_SETUP;
          w_load      = 1'b1;
        end
      end
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: if (w_strobe_last) w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Command latches, registered pin strobes decoded from the next state, read capture and acks
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id        <= RQ_CPU;
      r_rw        <= 1'b1;
      r_ad        <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_cs2       <= 1'b0;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ws_cnt    <= '0;
      r_vpu_run   <= '0;
      r_cpu_rdata <= '0;
      r_vpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_vpu_ack   <= 1'b0;
`ifdef SRAM_ARB_DMA_EN
      r_dma_rdata <= '0;
      r_dma_ack   <= 1'b0;
`endif
    end else begin
      r_cpu_ack <= 1'b0;
      r_vpu_ack <= 1'b0;
`ifdef SRAM_ARB_DMA_EN
      r_dma_ack <= 1'b0;
`endif
      if (w_load) begin
        r_id   <= w_grant_id;
        r_rw   <= w_sel_rw;
        r_ad   <= w_sel_addr;
        r_dq_o <= w_sel_wdata;
        if (w_grant_id == RQ_VPU) begin
          if (!w_run_full) r_vpu_run <= r_vpu_run + 1'b1;
        end else begin
          r_vpu_run <= '0;
        end
      end
      r_ws_cnt <= (r_state == ST_STROBE && !w_strobe_last) ? r_ws_cnt + 1'b1 : '0;
      r_cs2    <= (w_state_nxt != ST_IDLE);
      r_oe_n   <= !((w_state_nxt == ST_STROBE) && w_rw_nxt);
      r_we_n   <= !((w_state_nxt == ST_STROBE) && !w_rw_nxt);
      r_dq_oe  <= ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE)) && !w_rw_nxt;
      if (r_state == ST_STROBE && w_strobe_last) begin
        case (r_id)
          RQ_CPU: begin
            r_cpu_ack <= 1'b1;
            if (r_rw) r_cpu_rdata <= sram_dq_i;
          end
          RQ_VPU: begin
            r_vpu_ack   <= 1'b1;
            r_vpu_rdata <= sram_dq_i;
          end
`ifdef SRAM_ARB_DMA_EN
          RQ_DMA: begin
            r_dma_ack <= 1'b1;
            if (r_rw) r_dma_rdata <= sram_dq_i;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_hold   = cpu_req & ~r_cpu_ack & ~rst;
  assign vpu_rdata  = r_vpu_rdata;
  assign vpu_ack    = r_vpu_ack;
  assign sram_ad    = r_ad;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_cs2   = r_cs2;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;

endmodule
